// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg
// Shared definitions for the execute and write-back stages: the opcode set
// (including OP_MUL, which is only executable when EXE_MUL_EN is defined)
// and the field offsets of the {result, addr, opcode} DAO bus.
// No ports; imported by execute_stage and by write-back.
package execute_stage_pkg;

    localparam int OPC_W        = 4;
    localparam int DAO_OPC_LSB  = 0;
    localparam int DAO_ADDR_LSB = OPC_W;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ADD    = 4'h1,
        OP_SUB    = 4'h2,
        OP_AND    = 4'h3,
        OP_OR     = 4'h4,
        OP_XOR    = 4'h5,
        OP_SHL    = 4'h6,
        OP_SHR    = 4'h7,
        OP_MOV_SR = 4'h8,
        OP_MOV_RR = 4'h9,
        OP_MUL    = 4'hA
    } opcode_e;

    // The result field sits above the address field, whose width is a
    // parameter of the consumer.
    function automatic int dao_res_lsb(input int addr_w);
        return addr_w + OPC_W;
    endfunction

endpackage

// File: rtl/exe_mul_seq.sv
// exe_mul_seq
// Iterative shift-add multiplier, one multiplier bit per cycle, DATA_W
// iterations. Only instantiated when EXE_MUL_EN is defined.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (aborts a running multiply)
//   start    in   load a/b and begin; ignored while busy
//   a, b     in   DATA_W-bit operands
//   busy     out  iterations in progress
//   done     out  one-cycle pulse, product valid in the same cycle
//   product  out  2*DATA_W-bit product (held until the next start)
module exe_mul_seq #(
    parameter int DATA_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    logic                  busy_r;
    logic                  done_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2*DATA_W-1:0]   acc_r;
    logic [2*DATA_W-1:0]   mcand_r;
    logic [DATA_W-1:0]     mplier_r;

    // Load on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
        end else if (start && !busy_r) begin
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            cnt_r    <= '0;
            acc_r    <= '0;
            mcand_r  <= {{DATA_W{1'b0}}, a};
            mplier_r <= b;
        end else if (busy_r) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            // The last iteration raises done together with the final accumulate.
            done_r   <= (cnt_r == LAST_CNT);
            busy_r   <= (cnt_r != LAST_CNT);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Pipeline execute stage: accepts one decoded instruction at a time,
// computes the ALU result and presents {result, addr, opcode} on DAO until
// write-back acknowledges with data_read. Registered zero/carry flags and
// a one-cycle illegal_op pulse for unsupported opcodes.
// Optional feature macro: EXE_MUL_EN (adds OP_MUL via exe_mul_seq and the
// CALC state; without it OP_MUL is reported as illegal).
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   instr_valid  in   decode presents an instruction
//   instr_ready  out  stage is idle and can accept
//   opcode       in   4-bit operation code
//   op_a, op_b   in   DATA_W-bit source operands
//   dst_addr     in   ADDR_W-bit destination address (passed through)
//   DAO          out  {result, addr, opcode}
//   dao_valid    out  DAO holds an unconsumed result
//   data_read    in   write-back has sampled DAO
//   flag_z       out  last issued result was zero
//   flag_c       out  carry/borrow/shift-out/overflow of last issued result
//   illegal_op   out  one-cycle pulse after an unsupported opcode is accepted
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [3:0]                 opcode,
    input  logic [DATA_W-1:0]          op_a,
    input  logic [DATA_W-1:0]          op_b,
    input  logic [ADDR_W-1:0]          dst_addr,
    output logic [DATA_W+ADDR_W+3:0]   DAO,
    output logic                       dao_valid,
    input  logic                       data_read,
    output logic                       flag_z,
    output logic                       flag_c,
    output logic                       illegal_op
);

    localparam int RES_LSB = dao_res_lsb(ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef EXE_MUL_EN
        ST_CALC = 2'd1,
`endif
        ST_HOLD = 2'd2
    } state_e;

    state_e                      state_r;
    state_e                      state_next_s;

    opcode_e                     opc_r;
    logic [DATA_W-1:0]           a_r;
    logic [DATA_W-1:0]           b_r;
    logic [ADDR_W-1:0]           addr_r;

    logic                        accept_s;
    logic                        legal_s;
    logic                        is_mul_s;
    logic                        issue_r;
    logic                        issue_s;

    logic [DATA_W:0]             sum_s;
    logic [DATA_W:0]             diff_s;
    logic [DATA_W:0]             shl_s;
    logic [DATA_W:0]             shr_s;
    logic [DATA_W-1:0]           res_s;
    logic                        carry_s;

    logic [DATA_W+ADDR_W+3:0]    dao_r;
    logic                        dao_valid_r;
    logic                        flag_z_r;
    logic                        flag_c_r;
    logic                        illegal_r;
    logic                        ready_r;

`ifdef EXE_MUL_EN
    logic                        mul_start_s;
    logic                        mul_busy_s;
    logic                        mul_done_s;
    logic [2*DATA_W-1:0]         mul_prod_s;

    assign mul_start_s = accept_s && is_mul_s;

    exe_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy_s),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    assign issue_s = issue_r || ((state_r == ST_CALC) && mul_done_s);
`else
    assign issue_s = issue_r;
`endif

    // Acceptance and opcode legality decode on the incoming instruction.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && instr_valid;
        legal_s  = 1'b0;
        is_mul_s = 1'b0;
        case (opcode)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MOV_SR, OP_MOV_RR: begin
                legal_s = 1'b1;
            end
            OP_MUL: begin
                is_mul_s = 1'b1;
`ifdef EXE_MUL_EN
                legal_s  = 1'b1;
`else
                legal_s  = 1'b0;
`endif
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
`ifdef EXE_MUL_EN
                    if (is_mul_s) begin
                        state_next_s = ST_CALC;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
`else
                    state_next_s = ST_HOLD;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
`ifdef EXE_MUL_EN
            ST_CALC: begin
                // A multiplier that is neither busy nor done cannot finish;
                // fall back to IDLE rather than wait forever.
                if (mul_done_s) begin
                    state_next_s = ST_HOLD;
                end else if (!mul_busy_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
`endif
            ST_HOLD: begin
                if (dao_valid_r && data_read) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // ALU on the latched instruction; carries come out of one extra bit.
    always_comb begin
        sum_s   = {1'b0, a_r} + {1'b0, b_r};
        diff_s  = {1'b0, a_r} - {1'b0, b_r};
        // One guard bit each side catches the last bit shifted out; shifts
        // beyond DATA_W push only zeros through it.
        shl_s   = {1'b0, a_r} << b_r[3:0];
        shr_s   = {a_r, 1'b0} >> b_r[3:0];
        res_s   = '0;
        carry_s = 1'b0;
        case (opc_r)
            OP_ADD: begin
                res_s   = sum_s[DATA_W-1:0];
                carry_s = sum_s[DATA_W];
            end
            OP_SUB: begin
                res_s   = diff_s[DATA_W-1:0];
                carry_s = diff_s[DATA_W];
            end
            OP_AND: begin
                res_s = a_r & b_r;
            end
            OP_OR: begin
                res_s = a_r | b_r;
            end
            OP_XOR: begin
                res_s = a_r ^ b_r;
            end
            OP_SHL: begin
                res_s   = shl_s[DATA_W-1:0];
                carry_s = shl_s[DATA_W];
            end
            OP_SHR: begin
                res_s   = shr_s[DATA_W:1];
                carry_s = shr_s[0];
            end
            OP_MOV_SR, OP_MOV_RR: begin
                res_s = a_r;
            end
`ifdef EXE_MUL_EN
            OP_MUL: begin
                res_s   = mul_prod_s[DATA_W-1:0];
                carry_s = |mul_prod_s[2*DATA_W-1:DATA_W];
            end
`endif
            default: begin
                res_s   = '0;
                carry_s = 1'b0;
            end
        endcase
    end

    // Instruction capture, result issue, handshake and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opc_r       <= OP_NOP;
            a_r         <= '0;
            b_r         <= '0;
            addr_r      <= '0;
            issue_r     <= 1'b0;
            illegal_r   <= 1'b0;
            ready_r     <= 1'b1;
            dao_r       <= '0;
            dao_valid_r <= 1'b0;
            flag_z_r    <= 1'b0;
            flag_c_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                opc_r  <= opcode_e'(opcode);
                a_r    <= op_a;
                b_r    <= op_b;
                addr_r <= dst_addr;
            end else begin
                opc_r  <= opc_r;
                a_r    <= a_r;
                b_r    <= b_r;
                addr_r <= addr_r;
            end
            // Single-cycle ops issue on the edge after acceptance.
            issue_r   <= accept_s && legal_s && !is_mul_s;
            illegal_r <= accept_s && !legal_s;
            // Registered decode of the next state; data_read has no
            // combinational path to instr_ready.
            ready_r   <= (state_next_s == ST_IDLE);
            if (issue_s) begin
                dao_r[RES_LSB +: DATA_W]      <= res_s;
                dao_r[DAO_ADDR_LSB +: ADDR_W] <= addr_r;
                dao_r[DAO_OPC_LSB +: OPC_W]   <= opc_r;
                dao_valid_r                   <= 1'b1;
                flag_z_r                      <= (res_s == '0);
                flag_c_r                      <= carry_s;
            end else if (dao_valid_r && data_read) begin
                dao_valid_r <= 1'b0;
            end else begin
                dao_valid_r <= dao_valid_r;
            end
        end
    end

    assign instr_ready = ready_r;
    assign DAO         = dao_r;
    assign dao_valid   = dao_valid_r;
    assign flag_z      = flag_z_r;
    assign flag_c      = flag_c_r;
    assign illegal_op  = illegal_r;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Table-driven bench for execute_stage (DATA_W=14, ADDR_W=12): a vector
// table of single-cycle ops plus hand-written sequences for reset, the
// write-back hold, ignored inputs, illegal opcodes, multiply and reset abort.
module tb_execute_stage;
    import execute_stage_pkg::*;

    localparam int DW = 14;
    localparam int AW = 12;
    localparam int TW = DW + AW + 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           instr_valid;
    logic           instr_ready;
    logic [3:0]     opcode;
    logic [DW-1:0]  op_a;
    logic [DW-1:0]  op_b;
    logic [AW-1:0]  dst_addr;
    logic [TW-1:0]  DAO;
    logic           dao_valid;
    logic           data_read;
    logic           flag_z;
    logic           flag_c;
    logic           illegal_op;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] addr;
        logic [DW-1:0] res;
        logic          c;
        logic          z;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    execute_stage #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .op_a        (op_a),
        .op_b        (op_b),
        .dst_addr    (dst_addr),
        .DAO         (DAO),
        .dao_valid   (dao_valid),
        .data_read   (data_read),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal_op  (illegal_op)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] addr, input logic [DW-1:0] res,
                           input logic c, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.addr = addr; v.res = res; v.c = c; v.z = z;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] addr);
        instr_valid = 1'b1;
        opcode      = op;
        op_a        = a;
        op_b        = b;
        dst_addr    = addr;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        opcode      = 4'h0;
        op_a        = '0;
        op_b        = '0;
        dst_addr    = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk($sformatf("%s.dao", tag), 32'(DAO), 32'h0);
        chk($sformatf("%s.dao_valid", tag), 32'(dao_valid), 32'h0);
        chk($sformatf("%s.flag_z", tag), 32'(flag_z), 32'h0);
        chk($sformatf("%s.flag_c", tag), 32'(flag_c), 32'h0);
        chk($sformatf("%s.illegal_op", tag), 32'(illegal_op), 32'h0);
        chk($sformatf("%s.instr_ready", tag), 32'(instr_ready), 32'h1);
    endtask

    // Issue one single-cycle instruction, check latency, result and flags, then consume it.
    task automatic run_single(input vec_t v, input string tag);
        logic [TW-1:0] exp_dao;
        exp_dao = {v.res, v.addr, v.op};
        drive(v.op, v.a, v.b, v.addr);
        tick();
        idle_inputs();
        chk($sformatf("%s.valid_n", tag), 32'(dao_valid), 32'h0);
        chk($sformatf("%s.ready_n", tag), 32'(instr_ready), 32'h0);
        tick();
        chk($sformatf("%s.valid_n1", tag), 32'(dao_valid), 32'h1);
        chk($sformatf("%s.dao", tag), 32'(DAO), 32'(exp_dao));
        chk($sformatf("%s.flag_c", tag), 32'(flag_c), 32'(v.c));
        chk($sformatf("%s.flag_z", tag), 32'(flag_z), 32'(v.z));
        chk($sformatf("%s.ready_hold", tag), 32'(instr_ready), 32'h0);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        chk($sformatf("%s.valid_rd", tag), 32'(dao_valid), 32'h0);
        chk($sformatf("%s.ready_rd", tag), 32'(instr_ready), 32'h1);
    endtask

    initial begin
        logic [TW-1:0] exp_dao;
        vec_t          v;

        add_vec(OP_ADD,    14'h3FFF, 14'h0001, 12'h005, 14'h0000, 1'b1, 1'b1);
        add_vec(OP_SUB,    14'h0003, 14'h0005, 12'h0A5, 14'h3FFE, 1'b1, 1'b0);
        add_vec(OP_SHL,    14'h2001, 14'h0001, 12'h010, 14'h0002, 1'b1, 1'b0);
        add_vec(OP_SHR,    14'h2001, 14'h000F, 12'h011, 14'h0000, 1'b0, 1'b1);
        add_vec(OP_SHR,    14'h2001, 14'h0001, 12'h012, 14'h1000, 1'b1, 1'b0);
        add_vec(OP_SHL,    14'h0001, 14'h000E, 12'h013, 14'h0000, 1'b1, 1'b1);
        add_vec(OP_SHL,    14'h00FF, 14'h0000, 12'h014, 14'h00FF, 1'b0, 1'b0);
        add_vec(OP_SHL,    14'h0003, 14'h0012, 12'h015, 14'h000C, 1'b0, 1'b0);
        add_vec(OP_AND,    14'h3C3C, 14'h0FF0, 12'h020, 14'h0C30, 1'b0, 1'b0);
        add_vec(OP_OR,     14'h1234, 14'h0C0C, 12'h021, 14'h1E3C, 1'b0, 1'b0);
        add_vec(OP_XOR,    14'h3FFF, 14'h3FFF, 12'h022, 14'h0000, 1'b0, 1'b1);
        add_vec(OP_MOV_SR, 14'h0ABC, 14'h1234, 12'h7FF, 14'h0ABC, 1'b0, 1'b0);
        add_vec(OP_MOV_RR, 14'h0000, 14'h3FFF, 12'h800, 14'h0000, 1'b0, 1'b1);
        add_vec(OP_NOP,    14'h1111, 14'h2222, 12'hFFF, 14'h0000, 1'b0, 1'b1);
        add_vec(OP_ADD,    14'h1000, 14'h0234, 12'h030, 14'h1234, 1'b0, 1'b0);
        add_vec(OP_SUB,    14'h0005, 14'h0005, 12'h031, 14'h0000, 1'b0, 1'b1);
        add_vec(OP_SUB,    14'h0005, 14'h0003, 12'h032, 14'h0002, 1'b0, 1'b0);
        add_vec(OP_SHR,    14'h3FFF, 14'h000D, 12'h033, 14'h0001, 1'b1, 1'b0);
        add_vec(OP_SHR,    14'h3FFF, 14'h000E, 12'h034, 14'h0000, 1'b1, 1'b1);
        add_vec(OP_ADD,    14'h3FFF, 14'h3FFF, 12'h035, 14'h3FFE, 1'b1, 1'b0);

        reset     = 1'b1;
        data_read = 1'b0;
        idle_inputs();
        #2;
        reset = 1'b0;
        tick();
        tick();
        chk_reset_outs("reset");
        reset = 1'b1;
        tick();
        chk_reset_outs("post_reset");

        for (int i = 0; i < vq.size(); i++) begin
            run_single(vq[i], $sformatf("vec%0d", i));
        end

        // Illegal opcode: pulse for one cycle, nothing issued, flags untouched (last vec: c=1 z=0).
        drive(4'hF, 14'h0001, 14'h0001, 12'h001);
        tick();
        idle_inputs();
        chk("illegal.pulse", 32'(illegal_op), 32'h1);
        chk("illegal.valid", 32'(dao_valid), 32'h0);
        chk("illegal.ready", 32'(instr_ready), 32'h1);
        chk("illegal.flag_c", 32'(flag_c), 32'h1);
        chk("illegal.flag_z", 32'(flag_z), 32'h0);
        tick();
        chk("illegal.pulse_end", 32'(illegal_op), 32'h0);
        chk("illegal.valid2", 32'(dao_valid), 32'h0);

`ifndef EXE_MUL_EN
        // Without the multiplier OP_MUL is unsupported.
        drive(OP_MUL, 14'd100, 14'd50, 12'h001);
        tick();
        idle_inputs();
        chk("mul_off.pulse", 32'(illegal_op), 32'h1);
        chk("mul_off.valid", 32'(dao_valid), 32'h0);
        chk("mul_off.ready", 32'(instr_ready), 32'h1);
        tick();
        chk("mul_off.pulse_end", 32'(illegal_op), 32'h0);
        chk("mul_off.valid2", 32'(dao_valid), 32'h0);
        chk("mul_off.ready2", 32'(instr_ready), 32'h1);
`endif

        // SUB 3-5 held for 10 cycles while decode keeps offering another instruction.
        drive(OP_SUB, 14'h0003, 14'h0005, 12'h0A5);
        tick();
        idle_inputs();
        tick();
        exp_dao = {14'h3FFE, 12'h0A5, 4'(OP_SUB)};
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hold%0d.dao", k), 32'(DAO), 32'(exp_dao));
            chk($sformatf("hold%0d.valid", k), 32'(dao_valid), 32'h1);
            chk($sformatf("hold%0d.ready", k), 32'(instr_ready), 32'h0);
            drive(OP_ADD, 14'h0001, 14'h0001, 12'h003);
            tick();
        end
        idle_inputs();
        chk("hold.flag_c", 32'(flag_c), 32'h1);
        chk("hold.dao_end", 32'(DAO), 32'(exp_dao));
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        chk("hold.valid_rd", 32'(dao_valid), 32'h0);
        chk("hold.ready_rd", 32'(instr_ready), 32'h1);
        tick();
        chk("hold.no_capture_valid", 32'(dao_valid), 32'h0);
        chk("hold.no_capture_dao", 32'(DAO), 32'(exp_dao));

        // data_read held high before the result exists must be ignored.
        data_read = 1'b1;
        tick();
        chk("early_rd.idle_valid", 32'(dao_valid), 32'h0);
        drive(OP_ADD, 14'h1000, 14'h0234, 12'h040);
        tick();
        idle_inputs();
        chk("early_rd.valid_n", 32'(dao_valid), 32'h0);
        tick();
        chk("early_rd.valid_n1", 32'(dao_valid), 32'h1);
        chk("early_rd.dao", 32'(DAO), 32'({14'h1234, 12'h040, 4'(OP_ADD)}));
        tick();
        data_read = 1'b0;
        chk("early_rd.valid_rd", 32'(dao_valid), 32'h0);
        chk("early_rd.ready_rd", 32'(instr_ready), 32'h1);

`ifdef EXE_MUL_EN
        // MUL 100x50 = 5000: valid only after DATA_W+1 cycles.
        drive(OP_MUL, 14'd100, 14'd50, 12'h050);
        tick();
        idle_inputs();
        for (int k = 0; k <= DW; k++) begin
            chk($sformatf("mul1.wait%0d", k), 32'(dao_valid), 32'h0);
            chk($sformatf("mul1.ready%0d", k), 32'(instr_ready), 32'h0);
            tick();
        end
        chk("mul1.valid", 32'(dao_valid), 32'h1);
        chk("mul1.dao", 32'(DAO), 32'({14'h1388, 12'h050, 4'(OP_MUL)}));
        chk("mul1.flag_c", 32'(flag_c), 32'h0);
        chk("mul1.flag_z", 32'(flag_z), 32'h0);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        chk("mul1.valid_rd", 32'(dao_valid), 32'h0);

        // MUL 200x100 = 20000 = 0x4E20: low bits 0x0E20, overflow sets carry.
        drive(OP_MUL, 14'd200, 14'd100, 12'h051);
        tick();
        idle_inputs();
        for (int k = 0; k <= DW; k++) begin
            tick();
        end
        chk("mul2.valid", 32'(dao_valid), 32'h1);
        chk("mul2.dao", 32'(DAO), 32'({14'h0E20, 12'h051, 4'(OP_MUL)}));
        chk("mul2.flag_c", 32'(flag_c), 32'h1);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;

        // Reset in the middle of CALC aborts the multiply.
        drive(OP_MUL, 14'd7, 14'd9, 12'h052);
        tick();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        chk("abort.ready_calc", 32'(instr_ready), 32'h0);
`else
        // Reset in the middle of HOLD drops the pending result.
        drive(OP_ADD, 14'h0005, 14'h0005, 12'h052);
        tick();
        idle_inputs();
        tick();
        chk("abort.valid_hold", 32'(dao_valid), 32'h1);
`endif
        reset = 1'b0;
        #1;
        chk_reset_outs("abort");
        tick();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("abort.quiet%0d", k), 32'(dao_valid), 32'h0);
            tick();
        end
        v.op = OP_ADD; v.a = 14'h0002; v.b = 14'h0002; v.addr = 12'h060;
        v.res = 14'h0004; v.c = 1'b0; v.z = 1'b0;
        run_single(v, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the CPU pipeline, directly upstream of the write-back stage. It accepts one decoded instruction at a time, computes the ALU result, and packs `{result, addr, opcode}` onto the `DAO` bus. It holds `DAO` until the write-back stage signals consumption with `data_read`. It also produces registered zero/carry flags and flags unsupported opcodes.

## Interface
- `DATA_W`, default 14: data/operand width.
- `ADDR_W`, default 12: destination address width (GPR index or RAM address).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  decode presents an instruction.
- `instr_ready`  out  1  stage can accept; high only in IDLE.
- `opcode`  in  4  operation code (shared opcode set).
- `op_a`, `op_b`  in  DATA_W each  source operands.
- `dst_addr`  in  ADDR_W  destination address, passed through.
- `DAO`  out  DATA_W+ADDR_W+4  fields: `[DATA_W+ADDR_W+3:ADDR_W+4]` result, `[ADDR_W+3:4]` address, `[3:0]` opcode.
- `dao_valid`  out  1  `DAO` holds an unconsumed result.
- `data_read`  in  1  write-back has sampled `DAO`.
- `flag_z`, `flag_c`  out  1 each  zero/carry of the last issued result.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: IDLE, CALC, HOLD.
- IDLE:
  - `instr_valid` high latches opcode, operands and address.
  - Single-cycle ops compute in the same cycle and go to HOLD.
  - OP_MUL goes to CALC.
  - Unsupported opcode: pulse `illegal_op`, stay in IDLE, issue nothing.
- CALC: iterative multiply runs; on done, go to HOLD.
- HOLD:
  - `dao_valid`=1 and `DAO` stable.
  - `data_read`=1 clears `dao_valid` and returns to IDLE.
- Results:
  - OP_ADD: `op_a+op_b`, computed DATA_W+1 wide; `flag_c` = bit DATA_W.
  - OP_SUB: `op_a-op_b`; `flag_c` = borrow (`op_a<op_b`).
  - OP_AND / OP_OR / OP_XOR: bitwise; `flag_c`=0.
  - OP_SHL / OP_SHR: shift `op_a` logically by `op_b[3:0]`. A shift ≥ DATA_W gives 0. `flag_c` = last bit shifted out (0 for a shift of 0).
  - OP_MOV_SR and OP_MOV_RR: result = `op_a`, address = `dst_addr`, `flag_c`=0.
  - OP_NOP: result 0; issued so that write-back sequencing stays uniform.
  - `flag_z` = (result == 0).
- Flags are updated in the cycle `dao_valid` rises and held until the next issue.
- `data_read` while `dao_valid`=0 is ignored.
- `instr_valid` outside IDLE is ignored; the instruction is not captured.
- Reset value of every output is 0: `DAO`, `dao_valid`, `flag_z`, `flag_c`, `illegal_op`. `instr_ready` is 1 after reset (IDLE).
- Reset asserted mid-CALC or mid-HOLD aborts the operation; no result is issued.

## Timing
- Single-cycle op accepted on edge N: `dao_valid`=1 after edge N+1.
- OP_MUL accepted on edge N: `dao_valid`=1 after edge N+1+DATA_W.
- `data_read` sampled high on edge M: `dao_valid`=0 and `instr_ready`=1 after edge M.
- Peak throughput: one single-cycle instruction per 2 cycles, plus the write-back hold time.
- `instr_ready` is a decode of the state register only; there is no combinational path from `data_read`.
- `illegal_op` is high for exactly the cycle after the offending acceptance edge.

## Configuration
- `EXE_MUL_EN` defined:
  - OP_MUL supported via the shift-add multiplier, DATA_W iterations.
  - Result = low DATA_W bits of the product.
  - `flag_c` = 1 if any high product bit is set.
- `EXE_MUL_EN` undefined: OP_MUL is unsupported (`illegal_op` pulse), the CALC state and the multiplier are not compiled in, and no cycles are stalled.

## Structure
- The shared opcode include holds all `OP_*` codes, including OP_MUL, plus the DAO field offsets as constants. Write-back and execute both use it.
- The state encoding stays local.
- One sub-module, `exe_mul_seq`, under `EXE_MUL_EN`:
  - inputs: start, a, b
  - outputs: busy, done pulse, 2·DATA_W-bit product
  - one bit per cycle; aborted by `reset`.

## Test plan
- ADD `op_a`=14'h3FFF, `op_b`=1, `dst_addr`=12'h005 → `DAO` result 0, addr 5; `flag_z`=1, `flag_c`=1; `dao_valid` one cycle after acceptance.
- SUB 3−5 → result 14'h3FFE, `flag_c`=1. Then hold `data_read`=0 for 10 cycles → `DAO` stable, `instr_ready`=0, and a new `instr_valid` is ignored.
- SHL 14'h2001 by 1 → result 14'h0002, `flag_c`=1. SHR by 15 → result 0, `flag_z`=1.
- Unsupported opcode (OP_MUL with `EXE_MUL_EN` off) → `illegal_op` high for 1 cycle, `dao_valid` stays 0, `instr_ready` stays 1.
- `EXE_MUL_EN` on, MUL 100×50:
  - result 14'h1388, `flag_c`=0.
  - `dao_valid` after DATA_W+1 cycles.
  - MUL 200×100 → `flag_c`=1.
- `reset` low mid-CALC → all outputs 0, `instr_ready`=1. The next ADD 2+2 issues 4 normally.
